// File: rtl/ad_ip_jesd204_tpl_adc_fifo.sv
// ADC transport-layer capture FIFO: first-word-fall-through, drop-on-full with DRAIN recovery.
// Optional overflow beat counter on ovf_count when AD_TPL_ADC_FIFO_OVF_CNT_EN is defined.
module ad_ip_jesd204_tpl_adc_fifo #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture_en,
  input  logic [NUM_CHANNELS-1:0] adc_valid,
  input  logic [DATA_WIDTH-1:0]   adc_data,
  output logic                    adc_dovf,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
`ifdef AD_TPL_ADC_FIFO_OVF_CNT_EN
  output logic [15:0]             ovf_count,
`endif
  output logic [DATA_WIDTH-1:0]   m_axis_data
);

  localparam int unsigned AW    = FIFO_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FullCount = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t        state;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic                  beat;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  logic [AW:0]           count_after_pop;
  logic [AW:0]           count_next;
  logic [AW-1:0]         rd_next;
  logic [DATA_WIDTH-1:0] data_next;

  always_comb begin
    beat            = |adc_valid;
    // Full is judged on the registered count only; a same-cycle pop does not make room.
    full            = (count == FullCount);
    pop             = m_axis_valid & m_axis_ready;
    wr_en           = (state == StRun) & beat & ~full;
    drop            = beat & (((state == StRun) & full) | (state == StDrain));
    count_after_pop = count - {{AW{1'b0}}, pop};
    count_next      = count_after_pop + {{AW{1'b0}}, wr_en};
    rd_next         = rd_ptr + {{(AW-1){1'b0}}, pop};
    data_next       = m_axis_data;
    // Head slot being written this cycle bypasses the memory so the beat shows next cycle.
    if (wr_en && (count_after_pop == '0)) begin
      data_next = adc_data;
    end else if (count_next != '0) begin
      data_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      adc_dovf     <= 1'b0;
    end else begin
      count        <= count_next;
      rd_ptr       <= rd_next;
      wr_ptr       <= wr_ptr + {{(AW-1){1'b0}}, wr_en};
      m_axis_valid <= (count_next != '0);
      m_axis_data  <= data_next;
      adc_dovf     <= drop;
      if (!capture_en) begin
        state <= StIdle;
      end else begin
        unique case (state)
          StIdle:  state <= StRun;
          StRun:   if (drop) state <= StDrain;
          StDrain: if (count == '0) state <= StRun;
          default: state <= StIdle;
        endcase
      end
    end
  end

`ifdef AD_TPL_ADC_FIFO_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= 16'd0;
    end else if (drop && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_fifo.md
AD_IP_JESD204_TPL_ADC_FIFO -- requirements
Module: ad_ip_jesd204_tpl_adc_fifo

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of converter channels (width of adc_valid).
REQ-002 SHALL have parameter DATA_WIDTH, default 128: width of adc_data and m_axis_data.
REQ-003 SHALL have parameter FIFO_ADDR_WIDTH, default 4: FIFO depth is 2**FIFO_ADDR_WIDTH beats.
REQ-004 SHALL have port clk, input, 1: single clock (link_clk domain); all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port capture_en, input, 1: enables capture of ADC beats.
REQ-007 SHALL have port adc_valid, input, NUM_CHANNELS: per-channel valid from the transport layer; a beat is present when any bit is 1.
REQ-008 SHALL have port adc_data, input, DATA_WIDTH: beat data.
REQ-009 SHALL have port adc_dovf, output, 1: overflow indication back to the transport layer.
REQ-010 SHALL have port m_axis_valid, output, 1: output beat valid.
REQ-011 SHALL have port m_axis_ready, input, 1: downstream (DMA) ready.
REQ-012 SHALL have port m_axis_data, output, DATA_WIDTH: output beat data.

Function
REQ-013 SHALL implement a first-word-fall-through FIFO: m_axis_data = oldest stored beat whenever m_axis_valid=1.
REQ-014 SHALL hold occupancy count in 0..DEPTH; m_axis_valid = (count != 0), registered.
REQ-015 SHALL pop one beat per cycle where m_axis_valid & m_axis_ready.
REQ-016 SHALL give write-to-output latency of 1 cycle: beat accepted in cycle N -> visible on m_axis_* in N+1 if FIFO was empty.
REQ-017 SHALL keep m_axis_data stable while m_axis_valid=1 and m_axis_ready=0.
REQ-018 SHALL use FSM states IDLE, RUN, DRAIN.
REQ-019 IDLE: input beats ignored, no adc_dovf; capture_en=1 -> RUN next cycle.
REQ-020 RUN: beat present & count<DEPTH -> write; beat present & count==DEPTH -> drop beat, go DRAIN.
REQ-021 Full check SHALL NOT use same-cycle pop: beat at count==DEPTH is dropped even if a pop occurs that cycle.
REQ-022 DRAIN: all input beats dropped; count==0 -> RUN next cycle (if capture_en=1).
REQ-023 capture_en=0 in any state -> IDLE next cycle; stored beats continue to drain normally.
REQ-024 adc_dovf SHALL be registered, high exactly in cycle N+1 for each cycle N in which a beat was dropped in RUN or DRAIN.
REQ-025 Simultaneous write and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.

Reset
REQ-026 On rst=1 (asynchronous): state=IDLE, count=0, read/write pointers=0, m_axis_valid=0, adc_dovf=0, m_axis_data=0.
REQ-027 Reset mid-operation SHALL discard all stored beats; FIFO memory contents need not be cleared.
REQ-028 After rst release, first write no earlier than one cycle after capture_en=1 is seen.

Configuration
REQ-029 Macro AD_TPL_ADC_FIFO_OVF_CNT_EN defined: SHALL add output ovf_count, 16 bits, counting dropped beats, saturating at 0xFFFF, cleared only by rst (value 0).
REQ-030 Macro AD_TPL_ADC_FIFO_OVF_CNT_EN undefined: port ovf_count and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 capture_en=1, single beat adc_valid=4'hF, data=0x1234 at cycle 10, m_axis_ready=1 -> m_axis_valid=1, m_axis_data=0x1234 at cycle 11 only.
REQ-032 m_axis_ready=0, 17 consecutive beats (DEPTH=16) -> first 16 stored, 17th dropped, adc_dovf high one cycle, state DRAIN, ovf_count=1 (if enabled).
REQ-033 From REQ-032 state: continued beats with ready=1 -> all dropped, adc_dovf high each cycle until count=0, then RUN resumes writing; output order 0..15 intact.
REQ-034 Full FIFO, beat and pop in same cycle -> beat dropped, count 15.
REQ-035 capture_en=0 with 5 stored beats -> no new writes, no adc_dovf, 5 beats drain in order.
REQ-036 rst pulse asynchronously mid-stream with 8 stored -> m_axis_valid=0, adc_dovf=0 immediately; ovf_count=0.
